// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin share of one 32-bit barrel shifter between two requesters, single-entry result register.
// Optional macro ARITH_SHIFT_EN enables sign-filling arithmetic right shifts.
module shift_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int ID_W  = 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_data,
  input  logic [AMT_W-1:0] i_req0_amt,
  input  logic             i_req0_dir,
  input  logic             i_req0_arith,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_data,
  input  logic [AMT_W-1:0] i_req1_amt,
  input  logic             i_req1_dir,
  input  logic             i_req1_arith,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [WIDTH-1:0] o_resp_data,
  output logic [ID_W-1:0]  o_resp_id,
  output logic [15:0]      o_busy_cycles
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t             r_state, w_next;
  logic               r_rr_ptr;
  logic [WIDTH-1:0]   r_resp_data;
  logic [ID_W-1:0]    r_resp_id;
  logic [15:0]        r_busy;
  logic               w_slot_free, w_grant, w_accept, w_dir, w_fill;
  logic [WIDTH-1:0]   w_data, w_src, w_result;
  logic [AMT_W-1:0]   w_amt;
  logic [WIDTH-1:0]   w_stage [AMT_W+1];
  // Grant looks only at valids and rr_ptr, never at the requesters' data fields.
  assign w_slot_free  = (r_state == EMPTY) || i_resp_ready;
  assign w_grant      = (i_req0_valid && i_req1_valid) ? r_rr_ptr : i_req1_valid;
  assign o_req0_ready = i_reset_n && w_slot_free && i_req0_valid && !w_grant;
  assign o_req1_ready = i_reset_n && w_slot_free && i_req1_valid && w_grant;
  assign w_accept     = o_req0_ready || o_req1_ready;
  assign w_data = w_grant ? i_req1_data : i_req0_data;
  assign w_amt  = w_grant ? i_req1_amt  : i_req0_amt;
  assign w_dir  = w_grant ? i_req1_dir  : i_req0_dir;
`ifdef ARITH_SHIFT_EN
  logic w_arith;
  assign w_arith = w_grant ? i_req1_arith : i_req0_arith;
  assign w_fill  = w_arith && !w_dir && w_data[WIDTH-1];
`else
  logic w_unused_arith;
  assign w_unused_arith = i_req0_arith ^ i_req1_arith;
  assign w_fill = 1'b0;
`endif
  // Left shifts reuse the right-shift cascade on a bit-reversed operand.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) w_src[i] = w_dir ? w_data[WIDTH-1-i] : w_data[i];
    for (int i = 0; i < WIDTH; i++) w_result[i] = w_dir ? w_stage[AMT_W][WIDTH-1-i] : w_stage[AMT_W][i];
  end
  assign w_stage[0] = w_src;
  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    assign w_stage[s+1] = w_amt[s] ? {{(1 << s){w_fill}}, w_stage[s][WIDTH-1:(1 << s)]} : w_stage[s];
  end
  always_comb begin
    w_next = w_accept ? FULL : (i_resp_ready ? EMPTY : r_state);
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= EMPTY;
      r_rr_ptr    <= 1'b0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
      r_busy      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_resp_data <= w_result;
        r_resp_id   <= ID_W'(w_grant);
        r_rr_ptr    <= !w_grant;
      end
      if (r_state == FULL && !i_resp_ready && r_busy != 16'hFFFF) r_busy <= r_busy + 16'd1;
    end
  end
  assign o_resp_valid  = (r_state == FULL);
  assign o_resp_data   = r_resp_data;
  assign o_resp_id     = r_resp_id;
  assign o_busy_cycles = r_busy;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed and random checks of shift_unit_arbiter against a cycle model with a result scoreboard.
module tb_shift_unit_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        v0 = 0, v1 = 0, dir0 = 0, dir1 = 0, ar0 = 0, ar1 = 0, resp_ready = 0;
  logic [31:0] d0 = 0, d1 = 0;
  logic [4:0]  a0 = 0, a1 = 0;
  logic        ready0, ready1, resp_valid;
  logic [31:0] resp_data;
  logic [0:0]  resp_id;
  logic [15:0] busy;
  typedef struct {logic id; logic [31:0] data;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic        m_full = 0, m_rr = 0, m_id = 0;
  logic [31:0] m_data = 0;
  logic [15:0] m_busy = 0;
  int          n_asrt = 0, n_fail = 0;

  shift_unit_arbiter dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(ready0), .i_req0_data(d0), .i_req0_amt(a0), .i_req0_dir(dir0), .i_req0_arith(ar0),
    .i_req1_valid(v1), .o_req1_ready(ready1), .i_req1_data(d1), .i_req1_amt(a1), .i_req1_dir(dir1), .i_req1_arith(ar1),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data), .o_resp_id(resp_id),
    .o_busy_cycles(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] shf(logic [31:0] d, logic [4:0] a, logic dir, logic ar);
    if (dir) return d << a;
`ifdef ARITH_SHIFT_EN
    if (ar) return $unsigned($signed(d) >>> a);
`endif
    return d >> a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic free, g, e0, e1;
    #1;
    free = !m_full || resp_ready;
    g    = (v0 && v1) ? m_rr : v1;
    e0   = free && v0 && !g;
    e1   = free && v1 && g;
    chk("ready0", ready0, e0);
    chk("ready1", ready1, e1);
    if (e0 || e1) q.push_back('{g, g ? shf(d1, a1, dir1, ar1) : shf(d0, a0, dir0, ar0)});
    @(posedge clk);
    if (m_full && !resp_ready && m_busy != 16'hFFFF) m_busy++;
    if (e0 || e1) begin
      m_full = 1;
      m_rr   = !g;
    end else if (resp_ready) m_full = 0;
    @(negedge clk);
    chk("resp_valid", resp_valid, m_full);
    chk("busy_cycles", busy, m_busy);
    if (e0 || e1) begin
      if (q.size() == 0) chk("scoreboard_empty", 1, 0);
      else begin
        e = q.pop_front();
        m_data = e.data;
        m_id   = e.id;
      end
    end
    chk("resp_data", resp_data, m_data);
    chk("resp_id", resp_id, m_id);
  endtask

  task automatic model_reset();
    m_full = 0; m_rr = 0; m_id = 0; m_data = 0; m_busy = 0;
    q.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1;
    chk("init_valid", resp_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_id", resp_id, 0);
    @(negedge clk);
    rst_n = 1;
    resp_ready = 1;
    // Single logical / arithmetic right shift from requester 0
    v0 = 1; d0 = 32'h80000000; a0 = 4; dir0 = 0; ar0 = 0;
    step();
    chk("rshift_const", resp_data, 32'h08000000);
    chk("rshift_id", resp_id, 0);
    ar0 = 1;
    step();
`ifdef ARITH_SHIFT_EN
    chk("ashift_const", resp_data, 32'hF8000000);
`else
    chk("ashift_const", resp_data, 32'h08000000);
`endif
    v0 = 0; ar0 = 0;
    step();
    // Left shift and zero amount from requester 1
    v1 = 1; d1 = 32'h00000001; a1 = 31; dir1 = 1; ar1 = 1;
    step();
    chk("lshift_const", resp_data, 32'h80000000);
    chk("lshift_id", resp_id, 1);
    d1 = 32'h1234ABCD; a1 = 0; dir1 = 0; ar1 = 0;
    step();
    chk("amt0_const", resp_data, 32'h1234ABCD);
    v1 = 0;
    step();
    // Round robin from a fresh reset
    do_reset();
    v0 = 1; v1 = 1; dir0 = 0; dir1 = 1; d0 = 32'hF0F0_0000; d1 = 32'h0000_0F0F;
    for (int i = 0; i < 4; i++) begin
      a0 = 5'(i + 1); a1 = 5'(i + 2);
      step();
      chk("rr_id", resp_id, i % 2);
    end
    // Backpressure: hold the result for 5 cycles, then drain and refill in one cycle
    resp_ready = 0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_busy5", busy, 5);
    resp_ready = 1;
    step();
    v0 = 0; v1 = 0;
    step();
    // Random traffic
    for (int i = 0; i < 300; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); resp_ready = ($urandom_range(0, 3) != 0);
      d0 = $urandom; d1 = $urandom; a0 = 5'($urandom); a1 = 5'($urandom);
      dir0 = 1'($urandom); dir1 = 1'($urandom); ar0 = 1'($urandom); ar1 = 1'($urandom);
      step();
    end
    // Asynchronous reset while a result is held
    v0 = 1; v1 = 0; resp_ready = 0; d0 = 32'hDEADBEEF; a0 = 8; dir0 = 0; ar0 = 0;
    step();
    step();
    chk("pre_rst_valid", resp_valid, 1);
    do_reset();
    step();
    chk("post_rst_data", resp_data, 32'h00DEADBE);
    // Long stall saturates the counter
    v0 = 0;
    for (int i = 0; i < 70000; i++) step();
    chk("busy_sat", busy, 16'hFFFF);
    resp_ready = 1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
Shares one 32-bit barrel-shift datapath (right and left shift, 5-stage mux cascade) between two requesters, the execute-stage ALU port (req 0) and the multdiv sequencer (req 1). Each request is a valid/ready handshake. The block arbitrates round-robin, computes the shift combinationally, and holds the result in a single output register with its own valid/ready handshake. It sits between the execute stage and the shift datapath, replacing per-user shifter copies.

Parameters:
WIDTH, 32, operand and result width; must be 32 (amount field is fixed at 5 bits)
AMT_W, 5, shift-amount width
ID_W, 1, requester tag width (2 requesters)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 presents a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_data  in  32  operand
req0_amt  in  5  shift amount
req0_dir  in  1  0 = right, 1 = left
req0_arith  in  1  arithmetic right shift (see Optional Feature)
req1_valid, req1_ready, req1_data, req1_amt, req1_dir, req1_arith  same as requester 0, for requester 1
resp_valid  out  1  result register holds a valid result
resp_ready  in  1  consumer takes the result this cycle
resp_data  out  32  shifted result
resp_id  out  1  requester that issued the result
busy_cycles  out  16  count of cycles with resp_valid=1 and resp_ready=0 (stall counter)

Behaviour:
- Reset (reset_n=0, asynchronous): resp_valid=0, resp_data=0, resp_id=0, busy_cycles=0, rr_ptr=0, req*_ready=0. Outputs return to normal operation on the first rising edge after reset_n rises.
- States:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
  - "slot free" = EMPTY, or FULL with resp_ready=1 (drain and refill in the same cycle is allowed; full throughput is one result per cycle).
- Grant (combinational, only when slot free):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester selected by rr_ptr.
  - reqN_ready = slot free AND grant==N. At most one ready is high per cycle.
  - A ready signal must not depend on the same requester's own data fields.
- Accept (reqN_valid & reqN_ready at a rising edge):
  - resp_data <= shift(reqN_data, reqN_amt, reqN_dir, reqN_arith).
  - resp_id <= N; resp_valid <= 1; rr_ptr <= ~N.
  - Latency is exactly 1 cycle from accept to resp_valid.
- Drain without refill: resp_valid & resp_ready with no accept → resp_valid <= 0. resp_data and resp_id hold their last values.
- FULL with resp_ready=0: hold resp_data and resp_id stable; both readys stay 0; busy_cycles increments and saturates at 0xFFFF (no wrap).
- rr_ptr changes only on an accept. A lone requester does not starve the other: after any grant to N, the next contested cycle grants ~N.
- Shift rules:
  - amt=0 passes the operand unchanged.
  - Right shift fills with 0, or with bit 31 when arithmetic is enabled and selected.
  - Left shift fills with 0; the arith bit is ignored for left shifts.
  - amt is modulo 32 by width.
- Requesters must hold valid and fields stable until ready. The block does not check this; if a requester violates it, the result is whatever was presented at the accept edge.
- Reset mid-operation discards any held result with no response. Requesters re-present after reset.

Optional Feature:
Macro ARITH_SHIFT_EN.
- Defined: reqN_arith=1 with dir=0 performs a sign-extending right shift.
- Undefined: the reqN_arith inputs stay in the port list but are ignored; all right shifts are logical. The sign-fill logic is not synthesised.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with resp_valid=1 → resp_valid drops to 0 immediately (async); busy_cycles=0; after release, first accepted request responds next cycle.
- Single right shift: req0 data=0x80000000, amt=4, dir=0, arith=0, resp_ready=1 → accept cycle N, resp_valid=1 at N+1, resp_data=0x08000000, resp_id=0. With ARITH_SHIFT_EN and arith=1 → 0xF8000000; without the macro → 0x08000000.
- Left shift and zero amount: req1 data=0x00000001, amt=31, dir=1 → 0x80000000, resp_id=1. Then data=0x1234ABCD, amt=0 → 0x1234ABCD.
- Round-robin contention: both valid continuously for 4 cycles, resp_ready=1 → grants 0,1,0,1 (rr_ptr=0 after reset); one result per cycle; resp_id sequence 0,1,0,1.
- Backpressure: result held, resp_ready=0 for 5 cycles with both requesters valid → both readys stay 0; resp_data stable; busy_cycles=5. Raise resp_ready → same-cycle drain and refill, next result valid on the following cycle.
- Saturation: force a 70000-cycle stall → busy_cycles stops at 0xFFFF.
